// File: rtl/uart_core.sv
`timescale 1ns/1ps
// uart_core: single-clock UART transmitter and receiver, both timed by
// CLKS_PER_BIT cycle counters on clk. TX and RX run independently.
//
// Optional feature macro: UART_PARITY_EN (adds a parity bit to TX frames and
// a parity check in RX; PARITY_ODD selects odd parity). Undefined by default.
//
// Ports:
//   clk             system clock
//   reset           asynchronous active-low reset
//   i_tx_data       word to transmit, latched when a request is accepted
//   i_tx_ready      transmit request, ignored while o_tx_active is high
//   i_rx_data       asynchronous serial receive line (idles high)
//   o_tx_done       one-cycle pulse in the last cycle of the final stop bit
//   o_tx_active     high while a TX frame is in progress
//   o_tx_data       serial transmit line (idles high)
//   o_rx_data       last received word
//   o_rx_done       one-cycle pulse when o_rx_data updates
//   o_rx_frame_err  stop sample was 0 (valid with o_rx_done only)
//   o_rx_parity_err parity mismatch (valid with o_rx_done only)
module uart_core #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] i_tx_data,
   input  logic                 i_tx_ready,
   input  logic                 i_rx_data,
   output logic                 o_tx_done,
   output logic                 o_tx_active,
   output logic                 o_tx_data,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_done,
   output logic                 o_rx_frame_err,
   output logic                 o_rx_parity_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // Elaboration-time parameter range checks
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_core: DATA_BITS must be 5..9");
   end
   if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks
      $error("uart_core: CLKS_PER_BIT must be even and >= 4");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_core: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD > 1) begin : g_bad_parity
      $error("uart_core: PARITY_ODD must be 0 or 1");
   end

   // ---------------- transmitter ----------------
   state_t               r_tx_state;
   logic [CNT_W-1:0]     r_tx_cnt;
   logic [IDX_W-1:0]     r_tx_idx;
   logic                 r_tx_stop;
   logic [DATA_BITS-1:0] r_tx_shift;
`ifdef UART_PARITY_EN
   logic                 r_tx_par;
`endif

   // TX FSM; o_tx_data is loaded with the next bit on each bit boundary
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tx_state  <= S_IDLE;
         r_tx_cnt    <= '0;
         r_tx_idx    <= '0;
         r_tx_stop   <= 1'b0;
         r_tx_shift  <= '0;
         o_tx_data   <= 1'b1;
         o_tx_active <= 1'b0;
         o_tx_done   <= 1'b0;
`ifdef UART_PARITY_EN
         r_tx_par    <= 1'b0;
`endif
      end else begin
         o_tx_done <= 1'b0;
         case (r_tx_state)
            S_IDLE: begin
               if (i_tx_ready) begin
                  r_tx_shift  <= i_tx_data;
`ifdef UART_PARITY_EN
                  r_tx_par    <= ^i_tx_data ^ 1'(PARITY_ODD);
`endif
                  r_tx_cnt    <= '0;
                  r_tx_state  <= S_START;
                  o_tx_data   <= 1'b0;
                  o_tx_active <= 1'b1;
               end
            end
            S_START: begin
               if (r_tx_cnt == CNT_LAST) begin
                  r_tx_cnt   <= '0;
                  r_tx_idx   <= '0;
                  o_tx_data  <= r_tx_shift[0];
                  r_tx_shift <= r_tx_shift >> 1;
                  r_tx_state <= S_DATA;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_tx_cnt == CNT_LAST) begin
                  r_tx_cnt <= '0;
                  if (r_tx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                     o_tx_data  <= r_tx_par;
                     r_tx_state <= S_PARITY;
`else
                     o_tx_data  <= 1'b1;
                     r_tx_stop  <= 1'b0;
                     r_tx_state <= S_STOP;
`endif
                  end else begin
                     r_tx_idx   <= r_tx_idx + 1'b1;
                     o_tx_data  <= r_tx_shift[0];
                     r_tx_shift <= r_tx_shift >> 1;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (r_tx_cnt == CNT_LAST) begin
                  r_tx_cnt   <= '0;
                  o_tx_data  <= 1'b1;
                  r_tx_stop  <= 1'b0;
                  r_tx_state <= S_STOP;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            S_STOP: begin
               // Registered pulse must be set one edge early to land in the last cycle
               if (r_tx_cnt == CNT_PRE && r_tx_stop == STOP_LAST) begin
                  o_tx_done <= 1'b1;
               end
               if (r_tx_cnt == CNT_LAST) begin
                  r_tx_cnt <= '0;
                  if (r_tx_stop == STOP_LAST) begin
                     r_tx_state  <= S_IDLE;
                     o_tx_active <= 1'b0;
                  end else begin
                     r_tx_stop <= 1'b1;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            default: r_tx_state <= S_IDLE;
         endcase
      end
   end

   // ---------------- receiver ----------------
   logic                 r_rx_s1;
   logic                 r_rx_s2;
   logic                 w_rx_bit;
   state_t               r_rx_state;
   logic [CNT_W-1:0]     r_rx_cnt;
   logic [IDX_W-1:0]     r_rx_idx;
   logic [DATA_BITS-1:0] r_rx_shift;
   logic                 r_rx_wait_high;
`ifdef UART_PARITY_EN
   logic                 r_rx_par_err;
`endif

   // Two-flop synchroniser, reset to the idle (high) level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
      end else begin
         r_rx_s1 <= i_rx_data;
         r_rx_s2 <= r_rx_s1;
      end
   end

   assign w_rx_bit = r_rx_s2;

   // RX FSM; samples mid-bit, counting from the first low cycle seen in IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_state     <= S_IDLE;
         r_rx_cnt       <= '0;
         r_rx_idx       <= '0;
         r_rx_shift     <= '0;
         r_rx_wait_high <= 1'b0;
         o_rx_data      <= '0;
         o_rx_done      <= 1'b0;
         o_rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         r_rx_par_err    <= 1'b0;
         o_rx_parity_err <= 1'b0;
`endif
      end else begin
         o_rx_done      <= 1'b0;
         o_rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         o_rx_parity_err <= 1'b0;
`endif
         case (r_rx_state)
            S_IDLE: begin
               r_rx_cnt <= '0;
               // After a break the line must return high before re-arming
               if (r_rx_wait_high) begin
                  if (w_rx_bit) r_rx_wait_high <= 1'b0;
               end else if (!w_rx_bit) begin
                  r_rx_state <= S_START;
               end
            end
            S_START: begin
               if (r_rx_cnt == CNT_HALF) begin
                  r_rx_cnt <= '0;
                  r_rx_idx <= '0;
                  r_rx_state <= w_rx_bit ? S_IDLE : S_DATA;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_rx_cnt == CNT_LAST) begin
                  r_rx_cnt   <= '0;
                  r_rx_shift <= {w_rx_bit, r_rx_shift[DATA_BITS-1:1]};
                  if (r_rx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                     r_rx_state <= S_PARITY;
`else
                     r_rx_state <= S_STOP;
`endif
                  end else begin
                     r_rx_idx <= r_rx_idx + 1'b1;
                  end
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (r_rx_cnt == CNT_LAST) begin
                  r_rx_cnt   <= '0;
`ifdef UART_PARITY_EN
                  r_rx_par_err <= (^r_rx_shift ^ w_rx_bit) != 1'(PARITY_ODD);
`endif
                  r_rx_state <= S_STOP;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (r_rx_cnt == CNT_LAST) begin
                  r_rx_cnt       <= '0;
                  r_rx_state     <= S_IDLE;
                  o_rx_done      <= 1'b1;
                  o_rx_data      <= r_rx_shift;
                  o_rx_frame_err <= ~w_rx_bit;
                  r_rx_wait_high <= ~w_rx_bit && (r_rx_shift == '0);
`ifdef UART_PARITY_EN
                  o_rx_parity_err <= r_rx_par_err;
`endif
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            default: r_rx_state <= S_IDLE;
         endcase
      end
   end

`ifndef UART_PARITY_EN
   assign o_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
// tb_uart_core: self-checking bench for uart_core (default parameters).
// RX results are checked by a scoreboard queue; TX frames are checked
// cycle by cycle against a bench-built bit pattern.
module tb_uart_core;

   localparam int unsigned DB   = 8;
   localparam int unsigned CPB  = 16;
   localparam int unsigned SB   = 1;
   localparam int unsigned PODD = 0;
`ifdef UART_PARITY_EN
   localparam int unsigned PB = 1;
`else
   localparam int unsigned PB = 0;
`endif
   localparam int unsigned FRAME_BITS = 1 + DB + PB + SB;
   localparam int unsigned FRAME_CYC  = CPB * FRAME_BITS;

   logic          clk;
   logic          reset;
   logic [DB-1:0] tx_data;
   logic          tx_ready;
   logic          rx_line;
   logic          tb_rx;
   logic          loop_en;
   logic          tx_done;
   logic          tx_active;
   logic          tx_line;
   logic [DB-1:0] rx_data;
   logic          rx_done;
   logic          rx_ferr;
   logic          rx_perr;

   assign rx_line = loop_en ? tx_line : tb_rx;

   uart_core #(
      .DATA_BITS   (DB),
      .CLKS_PER_BIT(CPB),
      .STOP_BITS   (SB),
      .PARITY_ODD  (PODD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_tx_data      (tx_data),
      .i_tx_ready     (tx_ready),
      .i_rx_data      (rx_line),
      .o_tx_done      (tx_done),
      .o_tx_active    (tx_active),
      .o_tx_data      (tx_line),
      .o_rx_data      (rx_data),
      .o_rx_done      (rx_done),
      .o_rx_frame_err (rx_ferr),
      .o_rx_parity_err(rx_perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [DB-1:0] data;
      logic          ferr;
      logic          perr;
   } rx_exp_t;

   typedef struct {
      logic [DB-1:0] data;
      logic          stop_bit;
      logic          par_flip;
      logic          exp_ferr;
      logic          exp_perr;
   } rx_vec_t;

   rx_exp_t sb_q[$];
   rx_exp_t mon_e;
   int checks      = 0;
   int failures    = 0;
   int tx_done_cnt = 0;
   int rx_done_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic par_bit(input logic [DB-1:0] d);
      return ^d ^ 1'(PODD);
   endfunction

   // Output monitor: pops the scoreboard on every rx_done, counts pulses
   always @(negedge clk) begin
      if (reset) begin
         if (tx_done) tx_done_cnt++;
         if (rx_done) begin
            rx_done_cnt++;
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rx_unexpected actual=%0h expected=none", rx_data);
            end else begin
               mon_e = sb_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(mon_e.data));
               check("rx_frame_err", 32'(rx_ferr), 32'(mon_e.ferr));
               check("rx_parity_err", 32'(rx_perr), 32'(mon_e.perr));
            end
         end else if (rx_ferr || rx_perr) begin
            checks++;
            failures++;
            $display("FAIL rx_flags_outside_done actual=%0b%0b expected=00", rx_ferr, rx_perr);
         end
      end
   end

   // Serially drive one frame on tb_rx; called and returns at a negedge
   task automatic drive_rx(input logic [DB-1:0] d, input logic stop_bit, input logic par_flip);
      tb_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < int'(DB); i++) begin
         tb_rx = d[i];
         repeat (CPB) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      tb_rx = par_bit(d) ^ par_flip;
      repeat (CPB) @(negedge clk);
`else
      if (par_flip) tb_rx = 1'b1;
`endif
      tb_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      tb_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic wait_rx_drain(input string name);
      for (int i = 0; i < int'(4 * FRAME_CYC); i++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      check(name, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic wait_tx_done(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < int'(2 * FRAME_CYC); i++) begin
         @(negedge clk);
         if (tx_done) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, 32'(seen), 32'd1);
   endtask

   // Request one frame and check line, done and active on every cycle
   task automatic tx_frame(input logic [DB-1:0] d, input string tag);
      logic [FRAME_BITS-1:0] bits;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < int'(DB); i++) bits[1+i] = d[i];
`ifdef UART_PARITY_EN
      bits[1+DB] = par_bit(d);
`endif
      tx_data  = d;
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      tx_data  = ~d;
      for (int c = 1; c <= int'(FRAME_CYC); c++) begin
         check($sformatf("%s_line_c%0d", tag, c), 32'(tx_line), 32'(bits[(c-1)/int'(CPB)]));
         check($sformatf("%s_done_c%0d", tag, c), 32'(tx_done), 32'(c == int'(FRAME_CYC)));
         check($sformatf("%s_active_c%0d", tag, c), 32'(tx_active), 32'd1);
         tx_ready = (c == 40);
         @(negedge clk);
      end
      check({tag, "_idle_active"}, 32'(tx_active), 32'd0);
      check({tag, "_idle_line"}, 32'(tx_line), 32'd1);
      check({tag, "_idle_done"}, 32'(tx_done), 32'd0);
   endtask

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rx_vec_t vecs[6];
      int      base;
      logic [DB-1:0] lb_words[3];

      vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'(PB)};
      vecs[5] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0};
      lb_words = '{8'h00, 8'hFF, 8'h3C};

      reset    = 1'b0;
      tx_data  = '0;
      tx_ready = 1'b0;
      tb_rx    = 1'b1;
      loop_en  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_tx_line", 32'(tx_line), 32'd1);
      check("rst_tx_active", 32'(tx_active), 32'd0);
      check("rst_tx_done", 32'(tx_done), 32'd0);
      check("rst_rx_done", 32'(rx_done), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_rx_ferr", 32'(rx_ferr), 32'd0);
      check("rst_rx_perr", 32'(rx_perr), 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // TX 0xA5 with exact per-cycle waveform
      tx_frame(8'hA5, "txA5");

      // RX vector table
      for (int v = 0; v < 6; v++) begin
         sb_q.push_back('{vecs[v].data, vecs[v].exp_ferr, vecs[v].exp_perr});
         drive_rx(vecs[v].data, vecs[v].stop_bit, vecs[v].par_flip);
         wait_rx_drain($sformatf("rx_vec%0d_drain", v));
      end

      // Short low glitch must not produce a word; next frame still received
      base = rx_done_cnt;
      tb_rx = 1'b0;
      repeat (6) @(negedge clk);
      tb_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch_no_done", 32'(rx_done_cnt - base), 32'd0);
      sb_q.push_back('{8'hA3, 1'b0, 1'b0});
      drive_rx(8'hA3, 1'b1, 1'b0);
      wait_rx_drain("glitch_next_drain");

      // Break: one zero word with frame error, then re-arm after line high
      base = rx_done_cnt;
      sb_q.push_back('{8'h00, 1'b1, 1'((PB != 0) && (PODD != 0))});
      tb_rx = 1'b0;
      repeat (3 * FRAME_CYC) @(negedge clk);
      check("break_one_done", 32'(rx_done_cnt - base), 32'd1);
      tb_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      sb_q.push_back('{8'h5A, 1'b0, 1'b0});
      drive_rx(8'h5A, 1'b1, 1'b0);
      wait_rx_drain("break_rearm_drain");

      // Loopback, back-to-back frames with tx_ready held high
      loop_en = 1'b1;
      base = rx_done_cnt;
      tx_data = lb_words[0];
      sb_q.push_back('{lb_words[0], 1'b0, 1'b0});
      tx_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         wait_tx_done($sformatf("lb_txdone%0d", k));
         if (k < 3) begin
            tx_data = lb_words[k];
            sb_q.push_back('{lb_words[k], 1'b0, 1'b0});
         end else begin
            tx_ready = 1'b0;
         end
         if (k == 1) begin
            @(negedge clk);
            check("lb_gap_active", 32'(tx_active), 32'd0);
            check("lb_gap_line", 32'(tx_line), 32'd1);
            @(negedge clk);
            check("lb_restart_active", 32'(tx_active), 32'd1);
            check("lb_restart_line", 32'(tx_line), 32'd0);
         end
      end
      wait_rx_drain("lb_drain");
      check("lb_rx_count", 32'(rx_done_cnt - base), 32'd3);
      loop_en = 1'b0;
      repeat (2 * CPB) @(negedge clk);

      // Reset in the middle of data bit 4 aborts TX at once
      tx_data  = 8'h3C;
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      repeat (CPB * 5 + CPB / 2 - 1) @(negedge clk);
      check("midrst_active_before", 32'(tx_active), 32'd1);
      base = tx_done_cnt;
      #2 reset = 1'b0;
      #1;
      check("midrst_line", 32'(tx_line), 32'd1);
      check("midrst_active", 32'(tx_active), 32'd0);
      check("midrst_done", 32'(tx_done), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (FRAME_CYC) @(negedge clk);
      check("midrst_no_done", 32'(tx_done_cnt - base), 32'd0);
      check("midrst_idle_active", 32'(tx_active), 32'd0);
      tx_frame(8'hC3, "txC3");

      repeat (4) @(negedge clk);
      check("final_sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per bit period; even, >= 4.
REQ-003 Parameter STOP_BITS, default 1, stop bits transmitted per frame; legal values 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity; used only when UART_PARITY_EN is defined.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  single system clock; TX and RX both run on it; no derived baud clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 i_tx_data  input  DATA_BITS  parallel byte to transmit.
REQ-009 i_tx_ready  input  1  transmit request; accepted only when o_tx_active is low.
REQ-010 i_rx_data  input  1  asynchronous serial receive line; idles high.
REQ-011 o_tx_done  output  1  one-cycle pulse marking the end of a transmitted frame.
REQ-012 o_tx_active  output  1  high while a transmit frame is in progress.
REQ-013 o_tx_data  output  1  serial transmit line; idles high.
REQ-014 o_rx_data  output  DATA_BITS  last received word.
REQ-015 o_rx_done  output  1  one-cycle pulse when o_rx_data is updated.
REQ-016 o_rx_frame_err  output  1  stop-bit error flag; valid in the o_rx_done cycle only, 0 otherwise.
REQ-017 o_rx_parity_err  output  1  parity error flag; valid in the o_rx_done cycle only, 0 otherwise.

Function
REQ-018 TX FSM states: IDLE, START, DATA, PARITY, STOP; each bit is held for exactly CLKS_PER_BIT cycles.
REQ-019 IDLE: when i_tx_ready=1, latch i_tx_data and enter START on the next edge; o_tx_active rises in that same edge.
REQ-020 Frame order: start bit 0, data LSB first, parity bit (when present), then STOP_BITS ones.
REQ-021 o_tx_done pulses during the final cycle of the last stop bit; the FSM enters IDLE on the next edge and o_tx_active falls there.
REQ-022 Frame length: CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS) cycles, where P=1 if parity is present, else 0.
REQ-023 i_tx_ready while o_tx_active=1 is ignored; no queuing; i_tx_data changes mid-frame have no effect.
REQ-024 Back-to-back: i_tx_ready held high causes a new frame to start one cycle after o_tx_done, i.e. one idle-high cycle between frames.
REQ-025 RX path: i_rx_data passes through a 2-flop synchroniser before use; all RX timing below refers to the synchronised signal.
REQ-026 RX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-027 RX start detect: t0 is the first cycle the synchronised line is low in IDLE.
REQ-028 RX start check: the line is sampled at t0+CLKS_PER_BIT/2; if high, this is a false start and the FSM returns to IDLE with no pulse.
REQ-029 RX bit sampling: bit k (k=0 first data bit) is sampled at t0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT; parity, then the first stop bit, follow at the same spacing.
REQ-030 o_rx_done pulses one cycle after the stop sample; o_rx_data updates in the same cycle and holds until the next o_rx_done.
REQ-031 o_rx_frame_err=1 when the stop sample is 0; the word is still delivered.
REQ-032 Break condition: an all-zero line produces o_rx_done with data 0 and frame_err=1; RX then waits for the line to go high before re-arming start detection.
REQ-033 RX checks only the first stop bit; it re-arms in IDLE immediately after the stop sample.
REQ-034 TX and RX operate fully independently; simultaneous activity, including external loopback, is legal.

Reset
REQ-035 On reset low, both FSMs enter IDLE and all counters clear to 0.
REQ-036 Reset values: o_tx_data=1, o_tx_active=0, o_tx_done=0, o_rx_done=0, o_rx_data=0, both error flags 0; synchroniser flops reset to 1.
REQ-037 Reset asserted mid-frame aborts the frame immediately with no done pulse; the first frame after release behaves as from power-up.

Configuration
REQ-038 Macro UART_PARITY_EN: when defined, TX inserts a parity bit (even or odd per PARITY_ODD) and RX checks it, setting o_rx_parity_err on mismatch.
REQ-039 Without UART_PARITY_EN: no parity bit (P=0), PARITY states unreachable, o_rx_parity_err tied to 0.

Verification
REQ-040 TX 0xA5, defaults, no parity: line 0,1,0,1,0,0,1,0,1,1 at 16 cycles each; o_tx_done at cycle 160 of the frame.
REQ-041 Loopback o_tx_data->i_rx_data, send 0x00, 0xFF, 0x3C back-to-back with i_tx_ready held high -> three o_rx_done pulses, matching data, no errors.
REQ-042 RX 6-cycle low glitch on an idle line -> no o_rx_done, FSM back in IDLE.
REQ-043 RX frame 0x55 with stop bit forced 0 -> o_rx_done with data 0x55 and o_rx_frame_err=1.
REQ-044 UART_PARITY_EN, PARITY_ODD=0: RX 0x07 with parity bit 0 -> o_rx_parity_err=1; with parity bit 1 -> 0.
REQ-045 Reset pulse in the middle of TX bit 4 -> o_tx_data=1 and o_tx_active=0 asynchronously, no o_tx_done, next request transmits a correct frame.
